channel_row_scheduler: RTL and testbench
========================================

# channel_row_scheduler

Sequential replacement for the combinational row-to-channel mapper in the VGA trace renderer. Once per frame it latches the channel enable mask, counts the enabled channels, and computes the per-channel strip height with a multi-cycle divider. During the active scan it tracks rows with counters and reports the *actual* channel index, not the Nth-visible index, for each line. It sits between the VGA timing generator and the trace/pixel colouring logic.

## Interface
- MAX_CHAN_COUNT, 10, number of channel enable bits.
- OFFSET, 0, first display row belonging to channel area; rows above are header.
- VGA_VER_RES comes from `vga.h`. W = $clog2(VGA_VER_RES), which is 9 for 480. C = $clog2(MAX_CHAN_COUNT).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- channel_enable  in  MAX_CHAN_COUNT  per-channel enable mask.
- frame_start  in  1  one-cycle pulse in vertical blanking, before the first active row.
- line_start  in  1  one-cycle pulse at the start of each active row.
- pixel_row  in  W  row index; valid when line_start is high.
- ready  out  1  strip height computed for the current frame.
- is_channel  out  1  current row lies in a channel strip.
- channel_number  out  C  actual index of the enabled channel owning the row.
- separator  out  1  first row of a strip other than strip 0.

## Operation
- Reset values: ready=0, is_channel=0, channel_number=0, separator=0, state=IDLE.
- States and transitions:
  - IDLE → LATCH on frame_start.
  - LATCH: en_q ← channel_enable; count ← popcount. Takes 1 cycle, then → DIVIDE.
  - DIVIDE: restoring division (VGA_VER_RES−OFFSET)/count, one quotient bit per cycle, W cycles, then → SCAN.
  - If count==0, DIVIDE is skipped: height=0 and the block goes directly to SCAN.
  - SCAN: ready=1. Stays in SCAN until the next frame_start, which goes to LATCH.
- A frame_start in any state restarts at LATCH and drops ready to 0.
- channel_enable changes outside LATCH are ignored until the next frame_start.
- Behaviour in SCAN on each line_start:
  - pixel_row < OFFSET: is_channel=0 and the internal counters are held.
  - pixel_row == OFFSET: slot=0, chan_idx = lowest set bit of en_q, row_in_chan=0.
  - Otherwise: row_in_chan++. When row_in_chan == height−1, it wraps to 0, slot++, and chan_idx becomes the next set bit of en_q above chan_idx.
  - is_channel = (count≠0) && (slot < count) && (pixel_row ≥ OFFSET).
  - Remainder rows after count·height are therefore is_channel=0.
  - When is_channel=0, channel_number is held at its last value.
- A line_start outside SCAN forces is_channel=0.
- The row sequence within a frame is consecutive (one line_start per row, pixel_row +1 each time). Gaps are not supported.
- Arithmetic: dividend, divisor, height and row_in_chan are W bits. count is C+1 bits, so count == MAX_CHAN_COUNT does not overflow.

## Timing
- All outputs are registered and updated on the clk edge that samples line_start; they stay valid until the next line_start. Latency is 1 cycle.
- ready rises on the (W+2)th edge after the edge sampling frame_start: 1 LATCH + W DIVIDE + 1 transition edge. With count==0 it rises on the 2nd edge.
- The worst case of W+2 cycles is far inside vertical blanking. Requirement: frame_start must lead the first line_start by ≥ W+2 cycles.
- If frame_start and line_start are both high in the same cycle, frame_start wins and line_start is ignored.
- Reset asserted mid-DIVIDE or mid-SCAN clears all outputs immediately. The block stays in IDLE until the next frame_start.

## Configuration
- CHANNEL_SEPARATOR_EN defined: separator=1 for exactly the row with row_in_chan==0 && slot>0 && is_channel; the trace logic draws a divider line there.
- CHANNEL_SEPARATOR_EN undefined: separator is tied to 0 and its compare logic is removed. The port remains for interface stability.

## Test plan
- Reset: hold rst_n=0 with random inputs → ready, is_channel, channel_number and separator are all 0. After release, the outputs stay 0 until frame_start.
- Mask 10'b0000000101, OFFSET=0, 480 rows → ready after 11 cycles. Rows 0–239 give channel_number=0; rows 240–479 give channel_number=2. separator=1 only at row 240 (when CHANNEL_SEPARATOR_EN is defined).
- Mask 10'b0001111111 (7 channels) → height 68. Rows 0–67 give ch0, …, rows 408–475 give ch6, and rows 476–479 give is_channel=0.
- OFFSET=32, mask 10'b1000000011 → height 149. Rows 0–31 give is_channel=0; rows 32–180 give ch0, 181–329 give ch1, and 330–478 give ch9. Row 479 gives is_channel=0.
- Mask 0 → ready 2 cycles after frame_start; all rows give is_channel=0. Changing the mask mid-frame to 10'b1 has no effect until the next frame_start, after which rows 0–479 give ch0.
- Pulse rst_n low 3 cycles into DIVIDE → outputs clear immediately and ready stays 0 until the following frame_start completes, 11 cycles later.

Source files
------------

// File: rtl/channel_row_scheduler_if.sv
//------------------------------------------------------------------------------
// channel_row_scheduler_if
//
// Bundles the per-frame / per-line signals exchanged between the VGA timing
// side (master) and the channel_row_scheduler (slave).
//
// Parameters
//   MAX_CHAN_COUNT  number of channel enable bits
//   VGA_VER_RES     active display rows (normally taken from vga.h)
//
// Signals
//   channel_enable  master->slave  per-channel enable mask
//   frame_start     master->slave  one-cycle pulse in vertical blanking
//   line_start      master->slave  one-cycle pulse at the start of each row
//   pixel_row       master->slave  row index, valid with line_start
//   ready           slave->master  strip height computed for this frame
//   is_channel      slave->master  current row lies in a channel strip
//   channel_number  slave->master  actual index of the owning channel
//   separator       slave->master  first row of a strip other than strip 0
//------------------------------------------------------------------------------
interface channel_row_scheduler_if #(
   parameter int MAX_CHAN_COUNT = 10,
   parameter int VGA_VER_RES    = 480
);
   localparam int W = $clog2(VGA_VER_RES);
   localparam int C = $clog2(MAX_CHAN_COUNT);

   logic [MAX_CHAN_COUNT-1:0] channel_enable;
   logic                      frame_start;
   logic                      line_start;
   logic [W-1:0]              pixel_row;
   logic                      ready;
   logic                      is_channel;
   logic [C-1:0]              channel_number;
   logic                      separator;

   modport master (
      output channel_enable, frame_start, line_start, pixel_row,
      input  ready, is_channel, channel_number, separator
   );

   modport slave (
      input  channel_enable, frame_start, line_start, pixel_row,
      output ready, is_channel, channel_number, separator
   );
endinterface

// File: rtl/channel_row_scheduler.sv
//------------------------------------------------------------------------------
// channel_row_scheduler
//
// Maps display rows to trace channels for the VGA trace renderer. Once per
// frame it latches the channel enable mask, counts the enabled channels and
// derives the strip height (VGA_VER_RES-OFFSET)/count with a bit-serial
// restoring divider. During the active scan it follows the consecutive row
// sequence with counters and reports the actual channel index owning each row.
//
// Parameters
//   MAX_CHAN_COUNT  number of channel enable bits
//   OFFSET          first display row of the channel area (rows above: header)
//   VGA_VER_RES     active display rows (normally taken from vga.h)
//
// Ports
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    channel_row_scheduler_if.slave (mask, frame/line pulses, row in;
//          ready, is_channel, channel_number, separator out)
//
// Build option
//   CHANNEL_SEPARATOR_EN  when defined, separator flags the first row of every
//                         strip after strip 0; otherwise separator is tied 0.
//------------------------------------------------------------------------------
module channel_row_scheduler #(
   parameter int MAX_CHAN_COUNT = 10,
   parameter int OFFSET         = 0,
   parameter int VGA_VER_RES    = 480
) (
   input logic                     clk,
   input logic                     rst_n,
   channel_row_scheduler_if.slave  bus
);
   localparam int W  = $clog2(VGA_VER_RES);
   localparam int C  = $clog2(MAX_CHAN_COUNT);
   localparam int SW = $clog2(W);

   localparam logic [W-1:0]  DIVIDEND   = W'(VGA_VER_RES - OFFSET);
   localparam logic [W-1:0]  OFFSET_ROW = W'(OFFSET);
   localparam logic [SW-1:0] LAST_STEP  = SW'(W - 1);

   typedef enum logic [1:0] {IDLE, LATCH, DIVIDE, SCAN} state_t;

   state_t state, state_nx;

   // Frame configuration
   logic [MAX_CHAN_COUNT-1:0] en_q;
   logic [C:0]                count;
   logic [C:0]                popcnt;
   logic [W-1:0]              height;    // holds the dividend while dividing
   logic [W-1:0]              rem;
   logic [SW-1:0]             step;

   // Row tracking
   logic [C:0]   slot, slot_nx;
   logic [C-1:0] chan_idx, chan_idx_nx;
   logic [W-1:0] row_in_chan, row_in_chan_nx;
   logic         is_channel_nx, sep_nx;

   // Registered outputs
   logic         ready_q, is_channel_q, separator_q;
   logic [C-1:0] channel_number_q;

   // Divider step
   logic [W:0] trial, div_ext;

   // Row position relative to OFFSET; the borrow bit says "above the channel area"
   logic         below_offset;
   logic [W-1:0] row_rel;

   // Lowest set bit of mask at or above index start (0 if none).
   function automatic logic [C-1:0] first_set_from(input logic [MAX_CHAN_COUNT-1:0] mask,
                                                   input int start);
      logic [C-1:0] idx;
      logic         found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
         if (!found && i >= start && mask[i]) begin
            idx   = C'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   assign popcnt  = (C+1)'($countones(bus.channel_enable));
   assign trial   = {rem, height[W-1]};
   assign div_ext = (W+1)'(count);
   assign {below_offset, row_rel} = {1'b0, bus.pixel_row} - {1'b0, OFFSET_ROW};

   //---------------------------------------------------------------------------
   // FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every combinational output gets a default before any branch so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = IDLE;
         LATCH:   state_nx = (popcnt == '0) ? SCAN : DIVIDE;
         DIVIDE:  if (step == LAST_STEP) state_nx = SCAN;
         SCAN:    state_nx = SCAN;
         default: state_nx = IDLE;
      endcase
      // A new frame restarts from any state.
      if (bus.frame_start) state_nx = LATCH;
   end

   //---------------------------------------------------------------------------
   // Row tracking: next counter values for the row presented with line_start.
   // Rows arrive consecutively, so only the first channel row reloads; every
   // later row advances by one.
   //---------------------------------------------------------------------------
   always_comb begin
      slot_nx        = slot;
      chan_idx_nx    = chan_idx;
      row_in_chan_nx = row_in_chan;
      if (below_offset) begin
         // Header rows leave the counters untouched.
      end else if (row_rel == '0) begin
         slot_nx        = '0;
         chan_idx_nx    = first_set_from(en_q, 0);
         row_in_chan_nx = '0;
      end else if (row_in_chan == height - W'(1)) begin
         row_in_chan_nx = '0;
         chan_idx_nx    = first_set_from(en_q, int'(chan_idx) + 1);
         // Saturate at count so remainder rows never wrap back into a strip.
         if (slot < count) slot_nx = slot + (C+1)'(1);
      end else begin
         row_in_chan_nx = row_in_chan + W'(1);
      end
      is_channel_nx = (count != '0) && (slot_nx < count) && !below_offset;
   end

`ifdef CHANNEL_SEPARATOR_EN
   assign sep_nx = is_channel_nx && (row_in_chan_nx == '0) && (slot_nx != '0);
`else
   assign sep_nx = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Datapath
   //---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q             <= '0;
         count            <= '0;
         height           <= '0;
         rem              <= '0;
         step             <= '0;
         slot             <= '0;
         chan_idx         <= '0;
         row_in_chan      <= '0;
         ready_q          <= 1'b0;
         is_channel_q     <= 1'b0;
         channel_number_q <= '0;
         separator_q      <= 1'b0;
      end else begin
         ready_q <= !bus.frame_start && (state == SCAN);

         if (state == LATCH) begin
            en_q   <= bus.channel_enable;
            count  <= popcnt;
            height <= (popcnt == '0) ? '0 : DIVIDEND;
            rem    <= '0;
            step   <= '0;
         end

         // Restoring division: one quotient bit per cycle, MSB first. The
         // quotient shifts into height as the dividend shifts out of it.
         if (state == DIVIDE) begin
            step <= step + SW'(1);
            if (trial >= div_ext) begin
               rem    <= W'(trial - div_ext);
               height <= {height[W-2:0], 1'b1};
            end else begin
               rem    <= W'(trial);
               height <= {height[W-2:0], 1'b0};
            end
         end

         // frame_start takes priority: a coincident line_start is ignored.
         if (bus.line_start && !bus.frame_start) begin
            if (state == SCAN) begin
               slot         <= slot_nx;
               chan_idx     <= chan_idx_nx;
               row_in_chan  <= row_in_chan_nx;
               is_channel_q <= is_channel_nx;
               separator_q  <= sep_nx;
               if (is_channel_nx) channel_number_q <= chan_idx_nx;
            end else begin
               is_channel_q <= 1'b0;
               separator_q  <= 1'b0;
            end
         end
      end
   end

   assign bus.ready          = ready_q;
   assign bus.is_channel     = is_channel_q;
   assign bus.channel_number = channel_number_q;
   assign bus.separator      = separator_q;
endmodule

// File: tb/tb_channel_row_scheduler.sv
//------------------------------------------------------------------------------
// tb_channel_row_scheduler
//
// Directed bench for channel_row_scheduler. Two instances share the same
// stimulus: dut0 with OFFSET=0 and dut1 with OFFSET=32. Expected strip
// heights are hand-computed per mask; the per-row expectation derives the
// owning strip from (row-OFFSET)/height and a hand-written channel list.
//------------------------------------------------------------------------------
module tb_channel_row_scheduler;
   localparam int ROWS = 480;

`ifdef CHANNEL_SEPARATOR_EN
   localparam bit SEP_EN = 1'b1;
`else
   localparam bit SEP_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [9:0] channel_enable;
   logic       frame_start;
   logic       line_start;
   logic [8:0] pixel_row;

   int compared;
   int mismatched;
   int chmap[10];
   int last0, last1;

   channel_row_scheduler_if #(.MAX_CHAN_COUNT(10), .VGA_VER_RES(ROWS)) if0 ();
   channel_row_scheduler_if #(.MAX_CHAN_COUNT(10), .VGA_VER_RES(ROWS)) if1 ();

   assign if0.channel_enable = channel_enable;
   assign if0.frame_start    = frame_start;
   assign if0.line_start     = line_start;
   assign if0.pixel_row      = pixel_row;
   assign if1.channel_enable = channel_enable;
   assign if1.frame_start    = frame_start;
   assign if1.line_start     = line_start;
   assign if1.pixel_row      = pixel_row;

   channel_row_scheduler #(.MAX_CHAN_COUNT(10), .OFFSET(0), .VGA_VER_RES(ROWS)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   channel_row_scheduler #(.MAX_CHAN_COUNT(10), .OFFSET(32), .VGA_VER_RES(ROWS)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " d0 ready"}, 32'(if0.ready), 0);
      check({tag, " d0 is_channel"}, 32'(if0.is_channel), 0);
      check({tag, " d0 channel_number"}, 32'(if0.channel_number), 0);
      check({tag, " d0 separator"}, 32'(if0.separator), 0);
      check({tag, " d1 ready"}, 32'(if1.ready), 0);
      check({tag, " d1 is_channel"}, 32'(if1.is_channel), 0);
      check({tag, " d1 channel_number"}, 32'(if1.channel_number), 0);
      check({tag, " d1 separator"}, 32'(if1.separator), 0);
   endtask

   // Pulse frame_start with a new mask and check that ready drops at once and
   // rises exactly lat edges after the edge that sampled frame_start.
   task automatic start_frame(input logic [9:0] mask, input int lat);
      channel_enable = mask;
      frame_start    = 1'b1;
      tick();
      frame_start    = 1'b0;
      check($sformatf("m%03h ready drop d0", mask), 32'(if0.ready), 0);
      check($sformatf("m%03h ready drop d1", mask), 32'(if1.ready), 0);
      repeat (lat - 1) tick();
      check($sformatf("m%03h ready early d0", mask), 32'(if0.ready), 0);
      check($sformatf("m%03h ready early d1", mask), 32'(if1.ready), 0);
      tick();
      check($sformatf("m%03h ready rise d0", mask), 32'(if0.ready), 1);
      check($sformatf("m%03h ready rise d1", mask), 32'(if1.ready), 1);
   endtask

   task automatic check_dut(input string name, input int row, input int off, input int h,
                            input int n, input logic obs_ic, input logic [3:0] obs_ch,
                            input logic obs_sep, inout int last);
      int   rel, strip;
      logic exp_ic, exp_sep;
      rel     = 0;
      strip   = 0;
      exp_ic  = 1'b0;
      exp_sep = 1'b0;
      if (row >= off && h != 0) begin
         rel    = row - off;
         strip  = rel / h;
         exp_ic = (strip < n);
         if (exp_ic) begin
            last    = chmap[strip];
            exp_sep = SEP_EN && (strip > 0) && (rel % h == 0);
         end
      end
      check($sformatf("%s row %0d is_channel", name, row), 32'(obs_ic), 32'(exp_ic));
      check($sformatf("%s row %0d channel_number", name, row), 32'(obs_ch), 32'(last));
      check($sformatf("%s row %0d separator", name, row), 32'(obs_sep), 32'(exp_sep));
   endtask

   // Run a full frame of line_starts; optionally change the mask at chg_row.
   task automatic scan_frame(input int h0, input int h1, input int n,
                             input int chg_row, input logic [9:0] chg_mask);
      for (int row = 0; row < ROWS; row++) begin
         if (row == chg_row) channel_enable = chg_mask;
         pixel_row  = 9'(row);
         line_start = 1'b1;
         tick();
         line_start = 1'b0;
         check_dut("d0", row, 0, h0, n, if0.is_channel, if0.channel_number, if0.separator, last0);
         check_dut("d1", row, 32, h1, n, if1.is_channel, if1.channel_number, if1.separator, last1);
         tick();
      end
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      last0          = 0;
      last1          = 0;
      chmap          = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      rst_n          = 1'b0;
      channel_enable = '0;
      frame_start    = 1'b0;
      line_start     = 1'b0;
      pixel_row      = '0;

      // Reset held with random activity on the inputs.
      for (int i = 0; i < 4; i++) begin
         channel_enable = 10'($urandom);
         frame_start    = 1'($urandom_range(0, 1));
         line_start     = 1'($urandom_range(0, 1));
         pixel_row      = 9'($urandom_range(0, ROWS - 1));
         tick();
         check_idle_outputs($sformatf("in reset %0d", i));
      end
      channel_enable = 10'b0000000101;
      frame_start    = 1'b0;
      line_start     = 1'b0;
      rst_n          = 1'b1;

      // Out of reset but no frame_start yet: line_starts must leave outputs 0.
      for (int row = 0; row < 3; row++) begin
         pixel_row  = 9'(row);
         line_start = 1'b1;
         tick();
         line_start = 1'b0;
         tick();
         check_idle_outputs($sformatf("pre-frame row %0d", row));
      end

      // Two channels {0,2}: d0 height 480/2=240, d1 height 448/2=224.
      chmap = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
      start_frame(10'b0000000101, 11);
      scan_frame(240, 224, 2, -1, '0);

      // Empty mask: ready after 2 edges, no channel rows; mid-frame mask change ignored.
      start_frame(10'b0000000000, 2);
      scan_frame(0, 0, 0, 100, 10'b0000000001);

      // Single channel 0: whole area is ch0.
      chmap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      start_frame(10'b0000000001, 11);
      scan_frame(480, 448, 1, -1, '0);

      // Seven channels: d0 height 68 (rows 476-479 left over), d1 height 64.
      chmap = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0};
      start_frame(10'b0001111111, 11);
      scan_frame(68, 64, 7, -1, '0);

      // Channels {0,1,9}: d0 height 160, d1 height 149 (row 479 left over).
      chmap = '{0, 1, 9, 0, 0, 0, 0, 0, 0, 0};
      start_frame(10'b1000000011, 11);
      scan_frame(160, 149, 3, -1, '0);

      // Reset three cycles into DIVIDE clears outputs immediately.
      check("pre-reset d0 is_channel", 32'(if0.is_channel), 1);
      check("pre-reset d0 channel_number", 32'(if0.channel_number), 9);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async reset");
      last0 = 0;
      last1 = 0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (15) tick();
      check_idle_outputs("after reset idle");
      pixel_row  = 9'd0;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check_idle_outputs("after reset line");
      start_frame(10'b1000000011, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
